icache_direct: RTL and testbench

- Direct-mapped, one-word-per-block instruction cache between the fetch stage and memory_control's instruction port.
- Services hits combinationally from an internal frame array.
- On a miss, runs a single-word fill through iREN/iaddr/iload/iwait, then resumes.
- Read-only; no write-back, flush or coherence.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/icache_direct_if.sv | 36 +++
 rtl/icache_direct.sv | 122 ++++++++++++
 tb/tb_icache_direct.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package cpu_types_pkg;

    localparam int unsigned ICACHE_SETS  = 16;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    // Fetch address split for the default geometry
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side bus of the instruction cache.
// Statistics counters are present only when ICACHE_STATS_EN is defined.
interface icache_direct_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    // The cache itself
    modport slave (
        input  imemREN, imemaddr, iload, iwait,
        output imemload, ihit, iREN, iaddr
`ifdef ICACHE_STATS_EN
        , output hit_count, miss_count
`endif
    );

    // Datapath/memory side driving the cache
    modport master (
        output imemREN, imemaddr, iload, iwait,
        input  imemload, ihit, iREN, iaddr
`ifdef ICACHE_STATS_EN
        , input hit_count, miss_count
`endif
    );

endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block read-only instruction cache with single-word fill.
// Optional hit/miss counters under ICACHE_STATS_EN.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS = ICACHE_SETS
) (
    input  logic            CLK,
    input  logic            nRST,
    icache_direct_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    icache_state_t state, next_state;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];
    logic [29:0]      miss_word;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;

    logic        ihit_c;
    logic [31:0] imemload_c;
    logic        iren_c;
    logic [31:0] iaddr_c;
    logic        miss_c;
    logic        fill_c;
    logic        unused_ok;

    assign req_tag   = bus.imemaddr[31:IDX_W+2];
    assign req_idx   = bus.imemaddr[IDX_W+1:2];
    assign fill_tag  = miss_word[29:IDX_W];
    assign fill_idx  = miss_word[IDX_W-1:0];
    assign unused_ok = ^bus.imemaddr[1:0];

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and bus outputs; hits are serviced in the same cycle
    always_comb begin
        next_state = state;
        ihit_c     = 1'b0;
        imemload_c = 32'h0;
        iren_c     = 1'b0;
        iaddr_c    = 32'h0;
        miss_c     = 1'b0;
        fill_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
                    ihit_c     = 1'b1;
                    imemload_c = data_q[req_idx];
                end else if (bus.imemREN) begin
                    miss_c     = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iren_c  = 1'b1;
                iaddr_c = {miss_word, 2'b00};
                if (!bus.iwait) begin
                    fill_c     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.ihit     = ihit_c;
    assign bus.imemload = imemload_c;
    assign bus.iREN     = iren_c;
    assign bus.iaddr    = iaddr_c;

    // Fill always targets the latched miss address, not the live request
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) miss_word <= 30'h0;
        else if (miss_c) miss_word <= bus.imemaddr[31:2];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) valid_q <= '0;
        else if (fill_c) valid_q[fill_idx] <= 1'b1;
    end

    // Tag and data need no reset: they are qualified by valid_q
    always_ff @(posedge CLK) begin
        if (fill_c) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    // Free-running statistics, wrapping at 2^32
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if (ihit_c) hit_cnt  <= hit_cnt + 32'd1;
            if (miss_c) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct.
module tb_icache_direct;

    logic clk;
    logic nrst;
    int   n_checks;
    int   n_fail;

    icache_direct_if bus ();

    icache_direct dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic ren, input logic [31:0] addr);
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        nrst         = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.iload    = 32'h0;
        bus.iwait    = 1'b1;

        // Reset state
        #12;
        chk("rst_ihit", 32'(bus.ihit), 32'h0);
        chk("rst_iren", 32'(bus.iREN), 32'h0);
        chk("rst_iaddr", bus.iaddr, 32'h0);
        chk("rst_imemload", bus.imemload, 32'h0);
        nrst = 1'b1;
        tick();

        // Cold miss on 0x40 with three wait cycles
        req(1'b1, 32'h0000_0040);
        chk("cold_idle_ihit", 32'(bus.ihit), 32'h0);
        chk("cold_idle_iren", 32'(bus.iREN), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cold_wait_iren", 32'(bus.iREN), 32'h1);
            chk("cold_wait_iaddr", bus.iaddr, 32'h0000_0040);
            chk("cold_wait_ihit", 32'(bus.ihit), 32'h0);
        end
        tick();
        bus.iwait = 1'b0;
        bus.iload = 32'hDEAD_BEEF;
        #1;
        chk("cold_last_iren", 32'(bus.iREN), 32'h1);
        chk("cold_last_iaddr", bus.iaddr, 32'h0000_0040);
        tick();
        bus.iwait = 1'b1;
        bus.iload = 32'h0;
        #1;
        chk("cold_hit", 32'(bus.ihit), 32'h1);
        chk("cold_data", bus.imemload, 32'hDEAD_BEEF);

        // Same word, different byte offset
        req(1'b1, 32'h0000_0042);
        chk("off_hit", 32'(bus.ihit), 32'h1);
        chk("off_data", bus.imemload, 32'hDEAD_BEEF);
        chk("off_iren", 32'(bus.iREN), 32'h0);

        // Conflict on index 0: 0x80 evicts 0x40 and vice versa
        req(1'b1, 32'h0000_0080);
        chk("conf80_miss", 32'(bus.ihit), 32'h0);
        tick();
        chk("conf80_iaddr", bus.iaddr, 32'h0000_0080);
        bus.iwait = 1'b0;
        bus.iload = 32'h2222_2222;
        tick();
        bus.iwait = 1'b1;
        #1;
        chk("conf80_hit", 32'(bus.ihit), 32'h1);
        chk("conf80_data", bus.imemload, 32'h2222_2222);
        req(1'b1, 32'h0000_0040);
        chk("conf40_miss", 32'(bus.ihit), 32'h0);
        tick();
        chk("conf40_iren", 32'(bus.iREN), 32'h1);
        chk("conf40_iaddr", bus.iaddr, 32'h0000_0040);
        bus.iwait = 1'b0;
        bus.iload = 32'h1111_1111;
        tick();
        bus.iwait = 1'b1;
        #1;
        chk("conf40_data", bus.imemload, 32'h1111_1111);
        req(1'b1, 32'h0000_0080);
        chk("conf80_evicted", 32'(bus.ihit), 32'h0);
        req(1'b0, 32'h0000_0080);

        // iwait low and iload in IDLE must not fill anything
        bus.iwait = 1'b0;
        bus.iload = 32'hFFFF_FFFF;
        tick();
        chk("idle_iwait_iren", 32'(bus.iREN), 32'h0);
        bus.iwait = 1'b1;
        req(1'b1, 32'h0000_0080);
        chk("idle_iwait_nofill", 32'(bus.ihit), 32'h0);

        // Address change during fill: fill goes to 0x04, then 0x08 misses
        req(1'b1, 32'h0000_0004);
        chk("chg_miss", 32'(bus.ihit), 32'h0);
        tick();
        bus.imemaddr = 32'h0000_0008;
        bus.iwait    = 1'b0;
        bus.iload    = 32'hA5A5_A5A5;
        #1;
        chk("chg_iaddr_held", bus.iaddr, 32'h0000_0004);
        tick();
        bus.iwait = 1'b1;
        #1;
        chk("chg_idle_miss8", 32'(bus.ihit), 32'h0);
        chk("chg_idle_iren", 32'(bus.iREN), 32'h0);
        tick();
        chk("chg_fetch8_iren", 32'(bus.iREN), 32'h1);
        chk("chg_fetch8_iaddr", bus.iaddr, 32'h0000_0008);
        bus.iwait = 1'b0;
        bus.iload = 32'h8888_8888;
        tick();
        bus.iwait = 1'b1;
        #1;
        chk("chg_hit8_data", bus.imemload, 32'h8888_8888);
        req(1'b1, 32'h0000_0004);
        chk("chg_hit4", 32'(bus.ihit), 32'h1);
        chk("chg_hit4_data", bus.imemload, 32'hA5A5_A5A5);

        // Reset in the middle of a fetch
        req(1'b1, 32'h0000_0100);
        tick();
        chk("rstf_iren_before", 32'(bus.iREN), 32'h1);
        nrst = 1'b0;
        #1;
        chk("rstf_iren", 32'(bus.iREN), 32'h0);
        chk("rstf_iaddr", bus.iaddr, 32'h0);
        nrst = 1'b1;
        req(1'b1, 32'h0000_0004);
        chk("rstf_cleared4", 32'(bus.ihit), 32'h0);
        req(1'b1, 32'h0000_0100);
        chk("rstf_miss100", 32'(bus.ihit), 32'h0);
        tick();
        chk("rstf_refetch", bus.iaddr, 32'h0000_0100);
        bus.iwait = 1'b0;
        bus.iload = 32'h0100_0100;
        tick();
        bus.iwait = 1'b1;
        #1;
        chk("rstf_hit_data", bus.imemload, 32'h0100_0100);

`ifdef ICACHE_STATS_EN
        // Counters: fresh reset, two misses, five hit cycles, then wrap
        req(1'b0, 32'h0);
        nrst = 1'b0;
        #1;
        chk("st_rst_hits", bus.hit_count, 32'h0);
        chk("st_rst_miss", bus.miss_count, 32'h0);
        nrst = 1'b1;
        req(1'b1, 32'h0000_0200);
        tick();
        bus.iwait = 1'b0;
        bus.iload = 32'h0000_0200;
        tick();
        bus.iwait = 1'b1;
        req(1'b1, 32'h0000_0204);
        tick();
        bus.iwait = 1'b0;
        bus.iload = 32'h0000_0204;
        tick();
        bus.iwait = 1'b1;
        req(1'b1, 32'h0000_0200);
        for (int i = 0; i < 5; i++) tick();
        req(1'b0, 32'h0);
        chk("st_miss2", bus.miss_count, 32'd2);
        chk("st_hit5", bus.hit_count, 32'd5);
        force dut.hit_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt;
        req(1'b1, 32'h0000_0204);
        tick();
        req(1'b0, 32'h0);
        chk("st_hit_wrap", bus.hit_count, 32'h0);
        chk("st_miss_hold", bus.miss_count, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
